// File: rtl/sram_1w1r_fifo_ctrl_if.sv
// rtl/sram_1w1r_fifo_ctrl_if.sv - client push/pop handshake bundle for the 1W1R SRAM FIFO controller
interface sram_1w1r_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 240
);
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;

  modport master (
    output push_valid,
    output push_data,
    output pop_ready,
    input  push_ready,
    input  pop_valid,
    input  pop_data
  );

  modport slave (
    input  push_valid,
    input  push_data,
    input  pop_ready,
    output push_ready,
    output pop_valid,
    output pop_data
  );
endinterface

// File: rtl/sram_1w1r_fifo_ctrl.sv
// rtl/sram_1w1r_fifo_ctrl.sv - single-clock FIFO controller driving a 1W1R SRAM macro
// Write on port 0, read on port 1; a 3-entry output stage hides the macro's 2-cycle read latency.
module sram_1w1r_fifo_ctrl #(
  parameter int DATA_WIDTH = 240,
  parameter int ADDR_WIDTH = 5,
  parameter int OUT_DEPTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sram_1w1r_fifo_ctrl_if.slave  io_fifo,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_csb0,
  output logic [ADDR_WIDTH-1:0] o_addr0,
  output logic [DATA_WIDTH-1:0] o_din0,
  output logic                  o_csb1,
  output logic [ADDR_WIDTH-1:0] o_addr1,
  input  logic [DATA_WIDTH-1:0] i_dout1
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int OW    = $clog2(OUT_DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0]   r_mem_occ;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [1:0]            r_inflight_sr;
  logic [OW:0]           r_out_occ;
  logic [OW-1:0]         r_out_wp;
  logic [OW-1:0]         r_out_rp;
  logic [DATA_WIDTH-1:0] r_out_mem [OUT_DEPTH];

  logic                  r_csb0;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [DATA_WIDTH-1:0] r_din0;
  logic                  r_csb1;
  logic [ADDR_WIDTH-1:0] r_addr1;

  logic                  w_push_acc;
  logic                  w_pop;
  logic                  w_capture;
  logic                  w_read_iss;
  logic [1:0]            w_inflight;
  logic [3:0]            w_stage_used;
  logic                  w_push_ready;
  logic                  w_pop_valid;

  function automatic logic [OW-1:0] f_out_next(input logic [OW-1:0] p);
    return (p == OW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push_ready = (r_mem_occ < LP_DEPTH);
  assign w_pop_valid  = (r_out_occ != '0);
  assign w_push_acc   = io_fifo.push_valid && w_push_ready;
  assign w_pop        = w_pop_valid && io_fifo.pop_ready;
  assign w_capture    = r_inflight_sr[1];
  assign w_inflight   = {1'b0, r_inflight_sr[0]} + {1'b0, r_inflight_sr[1]};

  // A pop at this edge frees a slot in time for the read issued now; that credit is
  // what lets three entries sustain one word per cycle.
  assign w_stage_used = 4'(r_out_occ) + 4'(w_inflight) - 4'(w_pop);

  // r_mem_occ is the pre-edge value, so a word pushed at this very edge is never read
  // back in the same cycle and the two macro ports never collide on one address.
  assign w_read_iss   = (r_mem_occ != '0) && (w_stage_used < 4'(OUT_DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_mem_occ     <= '0;
      r_inflight_sr <= '0;
      r_out_occ     <= '0;
      r_out_wp      <= '0;
      r_out_rp      <= '0;
      r_csb0        <= 1'b1;
      r_addr0       <= '0;
      r_din0        <= '0;
      r_csb1        <= 1'b1;
      r_addr1       <= '0;
    end else begin
      r_csb0 <= ~w_push_acc;
      if (w_push_acc) begin
        r_addr0 <= r_wptr;
        r_din0  <= io_fifo.push_data;
        r_wptr  <= r_wptr + 1'b1;
      end

      r_csb1 <= ~w_read_iss;
      if (w_read_iss) begin
        r_addr1 <= r_rptr;
        r_rptr  <= r_rptr + 1'b1;
      end

      r_mem_occ     <= r_mem_occ + {{ADDR_WIDTH{1'b0}}, w_push_acc}
                                 - {{ADDR_WIDTH{1'b0}}, w_read_iss};
      r_inflight_sr <= {r_inflight_sr[0], w_read_iss};

      r_out_occ <= r_out_occ + {{OW{1'b0}}, w_capture} - {{OW{1'b0}}, w_pop};
      if (w_capture) r_out_wp <= f_out_next(r_out_wp);
      if (w_pop)     r_out_rp <= f_out_next(r_out_rp);
    end
  end

  // dout1 is only valid just before the capture edge; the shift register lands exactly there.
  always_ff @(posedge i_clk) begin
    if (w_capture) r_out_mem[r_out_wp] <= i_dout1;
  end

  assign io_fifo.push_ready = w_push_ready;
  assign io_fifo.pop_valid  = w_pop_valid;
  assign io_fifo.pop_data   = w_pop_valid ? r_out_mem[r_out_rp] : '0;

  assign o_count = r_mem_occ + (ADDR_WIDTH + 1)'(w_inflight) + (ADDR_WIDTH + 1)'(r_out_occ);
  assign o_csb0  = r_csb0;
  assign o_addr0 = r_addr0;
  assign o_din0  = r_din0;
  assign o_csb1  = r_csb1;
  assign o_addr1 = r_addr1;

endmodule

// File: tb/tb_sram_1w1r_fifo_ctrl.sv
// tb/tb_sram_1w1r_fifo_ctrl.sv - self-checking bench for sram_1w1r_fifo_ctrl with a behavioral 1W1R macro
module tb_sram_1w1r_fifo_ctrl;
  localparam int DW = 240;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   count;
  logic          csb0, csb1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout1;

  always #5 clk = ~clk;

  sram_1w1r_fifo_ctrl_if #(.DATA_WIDTH(DW)) fifo_if ();

  sram_1w1r_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_DEPTH(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_fifo (fifo_if.slave),
    .o_count (count),
    .o_csb0  (csb0),
    .o_addr0 (addr0),
    .o_din0  (din0),
    .o_csb1  (csb1),
    .o_addr1 (addr1),
    .i_dout1 (dout1)
  );

  // Macro model: inputs registered on posedge, array access on the following negedge.
  logic [DW-1:0] mem [1<<AW];
  logic          m_csb0 = 1'b1, m_csb1 = 1'b1;
  logic [AW-1:0] m_addr0, m_addr1;
  logic [DW-1:0] m_din0;
  always @(posedge clk) begin
    m_csb0  <= csb0;
    m_addr0 <= addr0;
    m_din0  <= din0;
    m_csb1  <= csb1;
    m_addr1 <= addr1;
  end
  always @(negedge clk) begin
    if (!m_csb0) mem[m_addr0] = m_din0;
    if (!m_csb1) dout1 <= mem[m_addr1];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          pop_ready;
    logic          e_csb0;
    logic [AW-1:0] e_addr0;
    logic          e_csb1;
    logic [AW-1:0] e_addr1;
    logic          e_pop_valid;
    logic [DW-1:0] e_pop_data;
    logic [AW:0]   e_count;
    logic          e_push_ready;
  } vec_t;

  vec_t vecs [11];
  logic [DW-1:0] w_a5, w_5a, zero;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_word;

  int accepted, popped, pushed, gaps, haz, bad, cnt_bad, cyc, first_push, first_pop, last_pop, stale;
  logic push_acc, pop_acc;

  initial begin
    w_a5 = {30{8'hA5}};
    w_5a = {30{8'h5A}};
    zero = '0;
    //             pv  data  pr csb0 a0 csb1 a1 pval pdata cnt prdy
    vecs[0]  = '{1'b1, w_a5, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, zero, 6'd1, 1'b1};
    vecs[1]  = '{1'b0, zero, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, zero, 6'd1, 1'b1};
    vecs[2]  = '{1'b0, zero, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, zero, 6'd1, 1'b1};
    vecs[3]  = '{1'b0, zero, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, w_a5, 6'd1, 1'b1};
    vecs[4]  = '{1'b0, zero, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, zero, 6'd0, 1'b1};
    vecs[5]  = '{1'b1, w_5a, 1'b0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, zero, 6'd1, 1'b1};
    vecs[6]  = '{1'b0, zero, 1'b0, 1'b1, 5'd1, 1'b0, 5'd1, 1'b0, zero, 6'd1, 1'b1};
    vecs[7]  = '{1'b0, zero, 1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, zero, 6'd1, 1'b1};
    vecs[8]  = '{1'b0, zero, 1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, w_5a, 6'd1, 1'b1};
    vecs[9]  = '{1'b0, zero, 1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, w_5a, 6'd1, 1'b1};
    vecs[10] = '{1'b0, zero, 1'b1, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, zero, 6'd0, 1'b1};

    fifo_if.push_valid = 1'b0;
    fifo_if.push_data  = '0;
    fifo_if.pop_ready  = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state held with no traffic
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_csb0", 256'(csb0), 256'(1));
      chk("rst_csb1", 256'(csb1), 256'(1));
      chk("rst_pop_valid", 256'(fifo_if.pop_valid), 256'(0));
      chk("rst_count", 256'(count), 256'(0));
    end
    chk("rst_push_ready", 256'(fifo_if.push_ready), 256'(1));
    chk("rst_addr0", 256'(addr0), 256'(0));
    chk("rst_addr1", 256'(addr1), 256'(0));
    chk("rst_din0", 256'(din0), 256'(0));
    chk("rst_pop_data", 256'(fifo_if.pop_data), 256'(0));

    // Single-word vectors
    for (int i = 0; i < 11; i++) begin
      fifo_if.push_valid = vecs[i].push_valid;
      fifo_if.push_data  = vecs[i].push_data;
      fifo_if.pop_ready  = vecs[i].pop_ready;
      step();
      chk($sformatf("v%0d_csb0", i), 256'(csb0), 256'(vecs[i].e_csb0));
      chk($sformatf("v%0d_addr0", i), 256'(addr0), 256'(vecs[i].e_addr0));
      chk($sformatf("v%0d_csb1", i), 256'(csb1), 256'(vecs[i].e_csb1));
      chk($sformatf("v%0d_addr1", i), 256'(addr1), 256'(vecs[i].e_addr1));
      chk($sformatf("v%0d_pop_valid", i), 256'(fifo_if.pop_valid), 256'(vecs[i].e_pop_valid));
      chk($sformatf("v%0d_pop_data", i), 256'(fifo_if.pop_data), 256'(vecs[i].e_pop_data));
      chk($sformatf("v%0d_count", i), 256'(count), 256'(vecs[i].e_count));
      chk($sformatf("v%0d_push_ready", i), 256'(fifo_if.push_ready), 256'(vecs[i].e_push_ready));
    end

    // Fill to the limit with the consumer stalled
    accepted = 0;
    fifo_if.pop_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      fifo_if.push_valid = 1'b1;
      fifo_if.push_data  = DW'(i);
      if (fifo_if.push_ready) accepted++;
      step();
    end
    fifo_if.push_valid = 1'b0;
    repeat (3) step();
    chk("fill_accepted", 256'(accepted), 256'(35));
    chk("fill_count", 256'(count), 256'(35));
    chk("fill_push_ready", 256'(fifo_if.push_ready), 256'(0));
    chk("fill_pop_valid", 256'(fifo_if.pop_valid), 256'(1));

    // Drain: one word per cycle, in order, across the pointer wrap
    popped = 0;
    gaps = 0;
    fifo_if.pop_ready = 1'b1;
    for (int c = 0; c < 100 && popped < 35; c++) begin
      if (fifo_if.pop_valid) begin
        chk($sformatf("drain_data%0d", popped), 256'(fifo_if.pop_data), 256'(popped));
        popped++;
      end else if (popped > 0) begin
        gaps++;
      end
      step();
    end
    chk("drain_popped", 256'(popped), 256'(35));
    chk("drain_gaps", 256'(gaps), 256'(0));
    chk("drain_count", 256'(count), 256'(0));

    // Streaming 100 words with both sides always ready
    pushed = 0; popped = 0; bad = 0; haz = 0; cyc = 0;
    first_push = -1; first_pop = -1; last_pop = -1;
    fifo_if.pop_ready = 1'b1;
    while (popped < 100 && cyc < 400) begin
      fifo_if.push_valid = (pushed < 100);
      fifo_if.push_data  = DW'(32'h1000 + pushed);
      if (fifo_if.push_valid && fifo_if.push_ready) begin
        if (first_push < 0) first_push = cyc;
        pushed++;
      end
      if (fifo_if.pop_valid) begin
        exp_word = DW'(32'h1000 + popped);
        if (fifo_if.pop_data !== exp_word) bad++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        popped++;
      end
      step();
      cyc++;
      if (!csb0 && !csb1 && addr0 == addr1) haz++;
    end
    fifo_if.push_valid = 1'b0;
    chk("stream_popped", 256'(popped), 256'(100));
    chk("stream_data_bad", 256'(bad), 256'(0));
    chk("stream_fill_latency", 256'(first_pop - first_push), 256'(4));
    chk("stream_span", 256'(last_pop - first_pop), 256'(99));
    chk("stream_addr_collision", 256'(haz), 256'(0));

    // Random traffic and backpressure against a scoreboard
    pushed = 0; popped = 0; bad = 0; cnt_bad = 0; cyc = 0;
    while (popped < 2000 && cyc < 20000) begin
      fifo_if.push_valid = (pushed < 2000) && ($urandom_range(0, 1) == 1);
      fifo_if.push_data  = DW'({$urandom(), $urandom(), $urandom(), $urandom(),
                                $urandom(), $urandom(), $urandom(), $urandom()});
      fifo_if.pop_ready  = ($urandom_range(0, 1) == 1);
      push_acc = fifo_if.push_valid && fifo_if.push_ready;
      pop_acc  = fifo_if.pop_valid && fifo_if.pop_ready;
      if (pop_acc) begin
        if (sb.size() == 0) bad++;
        else begin
          exp_word = sb.pop_front();
          if (fifo_if.pop_data !== exp_word) bad++;
        end
        popped++;
      end
      if (push_acc) begin
        sb.push_back(fifo_if.push_data);
        pushed++;
      end
      step();
      cyc++;
      if (int'(count) != sb.size()) cnt_bad++;
      if (!csb0 && !csb1 && addr0 == addr1) haz++;
    end
    fifo_if.push_valid = 1'b0;
    fifo_if.pop_ready  = 1'b0;
    chk("rand_popped", 256'(popped), 256'(2000));
    chk("rand_data_bad", 256'(bad), 256'(0));
    chk("rand_count_bad", 256'(cnt_bad), 256'(0));
    chk("rand_addr_collision", 256'(haz), 256'(0));

    // Reset with two reads in flight and a word already in the output stage
    for (int i = 0; i < 4; i++) begin
      fifo_if.push_valid = 1'b1;
      fifo_if.push_data  = DW'(32'h100 + i);
      step();
    end
    fifo_if.push_valid = 1'b0;
    chk("pre_rst_count", 256'(count), 256'(4));
    chk("pre_rst_pop_valid", 256'(fifo_if.pop_valid), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_csb0", 256'(csb0), 256'(1));
    chk("arst_csb1", 256'(csb1), 256'(1));
    chk("arst_addr0", 256'(addr0), 256'(0));
    chk("arst_addr1", 256'(addr1), 256'(0));
    chk("arst_din0", 256'(din0), 256'(0));
    chk("arst_pop_valid", 256'(fifo_if.pop_valid), 256'(0));
    chk("arst_pop_data", 256'(fifo_if.pop_data), 256'(0));
    chk("arst_count", 256'(count), 256'(0));
    chk("arst_push_ready", 256'(fifo_if.push_ready), 256'(1));
    repeat (2) step();
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fifo_if.pop_valid || count != '0) stale++;
    end
    chk("post_rst_stale", 256'(stale), 256'(0));

    fifo_if.push_valid = 1'b1;
    fifo_if.push_data  = DW'(1);
    fifo_if.pop_ready  = 1'b1;
    step();
    fifo_if.push_valid = 1'b0;
    cyc = 0;
    while (!fifo_if.pop_valid && cyc < 10) begin
      step();
      cyc++;
    end
    chk("post_rst_pop_valid", 256'(fifo_if.pop_valid), 256'(1));
    chk("post_rst_pop_data", 256'(fifo_if.pop_data), 256'(1));
    step();
    chk("post_rst_count", 256'(count), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
